// File: rtl/elevator_if.sv
// Elevator controller interface: floor calls in; car position, direction,
// door and latched calls out. The controller uses the slave view; whatever
// drives the call buttons uses the master view.
interface elevator_if;
    logic [3:0] call_req;
    logic [1:0] now_floor;
    logic [1:0] pointer;
    logic       door_state;
    logic [3:0] pending;

    modport master (
        output call_req,
        input  now_floor,
        input  pointer,
        input  door_state,
        input  pending
    );

    modport slave (
        input  call_req,
        output now_floor,
        output pointer,
        output door_state,
        output pending
    );
endinterface

// File: rtl/elevator_controller.sv
// Four-floor elevator controller. A prescaler turns clk into a slow tick;
// a per-state timer counts ticks to pace floor travel and door hold.
//
// state       | meaning
// ------------+-------------------------------------------------------
// S_IDLE      | door closed, car parked, picking the next call
// S_MOVE_UP   | travelling up one floor, re-entered per floor
// S_MOVE_DOWN | travelling down one floor, re-entered per floor
// S_DOOR_OPEN | door open at now_floor, held while its button is held
module elevator_controller #(
    parameter int unsigned TICK_DIV   = 100_000_000,
    parameter int unsigned MOVE_TICKS = 2,
    parameter int unsigned DOOR_TICKS = 3
) (
    input  logic      clk,
    input  logic      rst,
    elevator_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR_OPEN
    } state_t;

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    function automatic logic [3:0] onehot(input logic [1:0] f);
        return 4'b0001 << f;
    endfunction

    function automatic logic [3:0] above_of(input logic [1:0] f);
        return 4'b1110 << f;
    endfunction

    function automatic logic [3:0] below_of(input logic [1:0] f);
        return ~(4'b1111 << f);
    endfunction

    state_t        state, state_n;
    logic [1:0]    floor_q, floor_n;
    logic [3:0]    pend_q, pend_n;
    logic [1:0]    ptr_q, ptr_n;
    logic          door_q, door_n;
    logic          last_up_q, last_up_n;
    logic [31:0]   timer_q, timer_n;
    logic [PW-1:0] presc_q;
    logic          tick;
    logic          restart;
    logic          move_done;
    logic          door_done;
    logic [3:0]    here;
    logic [3:0]    set_mask;

    assign tick      = (presc_q == PW'(TICK_DIV - 1));
    assign move_done = tick && (timer_q == 32'(MOVE_TICKS - 1));
    assign door_done = tick && (timer_q == 32'(DOOR_TICKS - 1));
    assign here      = onehot(floor_q);

    assign bus.now_floor  = floor_q;
    assign bus.pointer    = ptr_q;
    assign bus.door_state = door_q;
    assign bus.pending    = pend_q;

    // Free-running prescaler producing the one-clk tick strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // State, car position, latched calls, timer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            floor_q   <= 2'd0;
            pend_q    <= 4'b0000;
            ptr_q     <= 2'b00;
            door_q    <= 1'b0;
            last_up_q <= 1'b1;
            timer_q   <= '0;
        end else begin
            state     <= state_n;
            floor_q   <= floor_n;
            pend_q    <= pend_n;
            ptr_q     <= ptr_n;
            door_q    <= door_n;
            last_up_q <= last_up_n;
            timer_q   <= timer_n;
        end
    end

    // Dispatch, travel and door sequencing plus the next output values.
    always_comb begin
        state_n   = state;
        floor_n   = floor_q;
        last_up_n = last_up_q;
        timer_n   = timer_q;
        restart   = 1'b0;
        ptr_n     = 2'b00;
        door_n    = 1'b0;

        // The button of the floor whose door is open extends the hold
        // instead of registering a new call.
        set_mask = bus.call_req & ~((state == S_DOOR_OPEN) ? here : 4'b0000);
        pend_n   = pend_q | set_mask;

        case (state)
            S_IDLE: begin
                if (|(pend_q & here)) begin
                    state_n = S_DOOR_OPEN;
                end else if (|(pend_q & above_of(floor_q)) && last_up_q) begin
                    state_n = S_MOVE_UP;
                end else if (|(pend_q & below_of(floor_q))) begin
                    state_n = S_MOVE_DOWN;
                end else if (|(pend_q & above_of(floor_q))) begin
                    state_n = S_MOVE_UP;
                end
            end
            S_MOVE_UP: begin
                if (floor_q == 2'd3) begin
                    state_n = S_IDLE;
                end else if (move_done) begin
                    floor_n = floor_q + 2'd1;
                    if (|(pend_q & onehot(floor_n))) begin
                        state_n = S_DOOR_OPEN;
                    end else if (|(pend_q & above_of(floor_n))) begin
                        restart = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_MOVE_DOWN: begin
                if (floor_q == 2'd0) begin
                    state_n = S_IDLE;
                end else if (move_done) begin
                    floor_n = floor_q - 2'd1;
                    if (|(pend_q & onehot(floor_n))) begin
                        state_n = S_DOOR_OPEN;
                    end else if (|(pend_q & below_of(floor_n))) begin
                        restart = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DOOR_OPEN: begin
                if (bus.call_req[floor_q]) begin
                    restart = 1'b1;
                end else if (door_done) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if ((state_n != state) || restart) begin
            timer_n = '0;
        end else if (tick) begin
            timer_n = timer_q + 32'd1;
        end

        // Serving a floor clears its call even if the button is pressed on
        // the same edge.
        if ((state_n == S_DOOR_OPEN) && (state != S_DOOR_OPEN)) begin
            pend_n = pend_n & ~onehot(floor_n);
        end

        if (state_n == S_MOVE_UP) begin
            last_up_n = 1'b1;
        end else if (state_n == S_MOVE_DOWN) begin
            last_up_n = 1'b0;
        end

        case (state_n)
            S_MOVE_UP:   ptr_n  = 2'b01;
            S_MOVE_DOWN: ptr_n  = 2'b10;
            S_DOOR_OPEN: door_n = 1'b1;
            default:     ptr_n  = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_elevator_controller.sv
// Bench for elevator_controller with a fast tick. Stimulus queues the floor
// expected at each door opening; a monitor pops it on every door opening and
// also checks floor steps, travel pacing, door dwell and pointer encoding.
module tb_elevator_controller;
    localparam int TICK_DIV   = 4;
    localparam int MOVE_TICKS = 2;
    localparam int DOOR_TICKS = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    elevator_if bus ();

    elevator_controller #(
        .TICK_DIV  (TICK_DIV),
        .MOVE_TICKS(MOVE_TICKS),
        .DOOR_TICKS(DOOR_TICKS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic pulse(input logic [3:0] v);
        @(posedge clk);
        #1 bus.call_req = v;
        @(posedge clk);
        #1 bus.call_req = 4'b0000;
    endtask

    task automatic wait_door(input logic v, input int budget, input string name);
        int n = 0;
        while (bus.door_state !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(bus.door_state), int'(v));
    endtask

    task automatic wait_floor(input logic [1:0] f, input int budget, input string name);
        int n = 0;
        while (bus.now_floor !== f && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(bus.now_floor), int'(f));
    endtask

    // Monitor: scoreboard pop on door opening plus continuous motion checks.
    int         cyc = 0;
    int         open_cnt = 0;
    int         last_step = 0;
    int         mon_exp = 0;
    bit         prev_door = 1'b0;
    bit         extended = 1'b0;
    bit         cont = 1'b0;
    logic [1:0] prev_floor = 2'd0;
    logic [1:0] prev_ptr = 2'd0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            prev_door  = 1'b0;
            extended   = 1'b0;
            cont       = 1'b0;
            open_cnt   = 0;
            prev_floor = 2'd0;
            prev_ptr   = 2'd0;
        end else begin
            check("pointer_legal", int'(bus.pointer != 2'b11), 1);
            if (bus.now_floor != prev_floor) begin
                if (prev_ptr == 2'b01) begin
                    check("step_up", int'(bus.now_floor), int'(prev_floor) + 1);
                end else if (prev_ptr == 2'b10) begin
                    check("step_down", int'(bus.now_floor), int'(prev_floor) - 1);
                end else begin
                    check("step_without_direction", int'(prev_ptr), 1);
                end
                if (cont) check("step_interval", cyc - last_step, MOVE_TICKS * TICK_DIV);
                last_step = cyc;
                cont      = 1'b1;
            end
            if (bus.pointer == 2'b00) cont = 1'b0;

            if (bus.door_state && !prev_door) begin
                open_cnt = 0;
                extended = 1'b0;
                if (exp_q.size() == 0) begin
                    check("door_unexpected_at_floor", int'(bus.now_floor), -1);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("door_floor", int'(bus.now_floor), mon_exp);
                    check("door_pending_cleared", int'(bus.pending[bus.now_floor]), 0);
                    check("door_pointer", int'(bus.pointer), 0);
                end
            end
            if (bus.door_state) begin
                open_cnt++;
                if (bus.call_req[bus.now_floor]) extended = 1'b1;
            end
            if (!bus.door_state && prev_door) begin
                if (extended) check_range("door_dwell_held", open_cnt, 9, 1000);
                else          check_range("door_dwell", open_cnt, 9, 12);
            end

            prev_door  = bus.door_state;
            prev_floor = bus.now_floor;
            prev_ptr   = bus.pointer;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.call_req = 4'b0000;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_floor", int'(bus.now_floor), 0);
        check("reset_pointer", int'(bus.pointer), 0);
        check("reset_door", int'(bus.door_state), 0);
        check("reset_pending", int'(bus.pending), 0);
        rst = 1'b1;

        // Call at the current floor: door opens on the dispatch edge.
        exp_q.push_back(0);
        pulse(4'b0001);
        @(posedge clk);
        #1;
        check("f0_door_open", int'(bus.door_state), 1);
        check("f0_pending", int'(bus.pending), 0);
        wait_door(1'b0, 40, "f0_door_close");

        // Travel 0 -> 3.
        exp_q.push_back(3);
        pulse(4'b1000);
        @(posedge clk);
        #1;
        check("up_pointer", int'(bus.pointer), 1);
        wait_floor(2'd3, 60, "up_reach_3");
        wait_door(1'b1, 5, "up_door_open_3");
        check("up_pending_3", int'(bus.pending), 0);
        wait_door(1'b0, 40, "up_door_close_3");

        // Asynchronous reset while moving down at floor 2.
        pulse(4'b0001);
        wait_floor(2'd2, 40, "rst_reach_2");
        check("rst_moving_down", int'(bus.pointer), 2);
        #2 rst = 1'b0;
        #1;
        check("async_rst_floor", int'(bus.now_floor), 0);
        check("async_rst_pointer", int'(bus.pointer), 0);
        check("async_rst_door", int'(bus.door_state), 0);
        check("async_rst_pending", int'(bus.pending), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_pointer", int'(bus.pointer), 0);
        check("post_rst_floor", int'(bus.now_floor), 0);

        // Moving up at floor 2 with calls at 3 and 0: 3 served first.
        exp_q.push_back(3);
        exp_q.push_back(0);
        pulse(4'b1000);
        wait_floor(2'd2, 40, "sweep_reach_2");
        pulse(4'b0001);
        @(negedge clk);
        check("sweep_pending", int'(bus.pending), 9);
        check("sweep_floor", int'(bus.now_floor), 2);
        check("sweep_pointer", int'(bus.pointer), 1);
        wait_floor(2'd3, 40, "sweep_reach_3");
        wait_door(1'b0, 40, "sweep_door_close_3");
        @(posedge clk);
        #1;
        check("sweep_pointer_down", int'(bus.pointer), 2);
        wait_floor(2'd0, 80, "sweep_reach_0");
        wait_door(1'b1, 5, "sweep_door_open_0");
        wait_door(1'b0, 40, "sweep_door_close_0");

        // Door hold at floor 1.
        exp_q.push_back(1);
        pulse(4'b0010);
        wait_door(1'b1, 40, "hold_door_open");
        @(posedge clk);
        #1 bus.call_req = 4'b0010;
        repeat (MOVE_TICKS * TICK_DIV) @(posedge clk);
        #1 bus.call_req = 4'b0000;
        check("hold_door_still_open", int'(bus.door_state), 1);
        check("hold_pending", int'(bus.pending), 0);
        n = 0;
        while (bus.door_state && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_range("hold_release_to_close", n, 9, 12);

        // Down sweep 3 -> 0 with a late call at 2.
        exp_q.push_back(3);
        pulse(4'b1000);
        wait_door(1'b1, 60, "late_door_open_3");
        wait_door(1'b0, 40, "late_door_close_3");
        exp_q.push_back(0);
        exp_q.push_back(2);
        pulse(4'b0001);
        wait_floor(2'd1, 60, "late_reach_1");
        check("late_pointer_down", int'(bus.pointer), 2);
        pulse(4'b0100);
        wait_floor(2'd0, 40, "late_reach_0");
        wait_floor(2'd2, 80, "late_reach_2");
        wait_door(1'b1, 5, "late_door_open_2");
        wait_door(1'b0, 40, "late_door_close_2");

        repeat (4) @(posedge clk);
        #1;
        check("end_queue_empty", exp_q.size(), 0);
        check("end_pending", int'(bus.pending), 0);
        check("end_pointer", int'(bus.pointer), 0);
        check("end_floor", int'(bus.now_floor), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/elevator_controller.md
ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000, number of clk cycles per timing tick (1 s at 100 MHz).
REQ-002 Parameter MOVE_TICKS, default 2, ticks spent travelling one floor.
REQ-003 Parameter DOOR_TICKS, default 3, ticks the door is held open.
REQ-004 clk  input  1  system clock; the only clock in the block.
REQ-005 rst  input  1  asynchronous, active-low reset; 0 resets the block immediately, independent of clk.
REQ-006 call_req  input  4  floor call buttons, one bit per floor 0..3, level-sampled every clk.
REQ-007 now_floor  output  2  current floor, 0..3, feeds the VGA display.
REQ-008 pointer  output  2  travel direction: 00 none, 01 up, 10 down; 11 is never driven.
REQ-009 door_state  output  1  1 = door open, 0 = closed.
REQ-010 pending  output  4  latched, unserved calls.

Function
REQ-011 Prescaler: counts 0..TICK_DIV-1 free-running and wraps; tick is a one-clk strobe when it equals TICK_DIV-1.
REQ-012 State timer: clears on every state entry and increments on tick; a state's timeout fires on the tick where timer equals N-1 (N = MOVE_TICKS or DOOR_TICKS).
REQ-013 States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; all outputs are registered.
REQ-014 Call latching: pending[i] sets on any clk where call_req[i]=1, except per REQ-020; it clears only through service (REQ-019) or reset.
REQ-015 IDLE: pointer=00, door_state=0; the next clk edge dispatches in this priority order: pending[now_floor] goes to DOOR_OPEN; else a call above with last_dir=up goes to MOVE_UP; else a call below goes to MOVE_DOWN; else a call above goes to MOVE_UP; else the block stays in IDLE.
REQ-016 last_dir register: set to up on MOVE_UP entry and to down on MOVE_DOWN entry; resets to up.
REQ-017 MOVE_UP/MOVE_DOWN: pointer=01/10, door_state=0; at timeout now_floor increments/decrements by 1 on that edge.
REQ-018 On arrival: if pending[new floor], go to DOOR_OPEN; else if calls remain further in the same direction, re-enter the same MOVE state with the timer cleared; else go to IDLE.
REQ-019 DOOR_OPEN entry: pending[now_floor] clears on the entry edge; door_state=1, pointer=00.
REQ-020 In DOOR_OPEN, call_req[now_floor]=1 does not set pending and instead clears the timer (door hold extended).
REQ-021 DOOR_OPEN timeout goes to IDLE with door_state=0; IDLE dispatches on the following edge.
REQ-022 Bounds: MOVE_UP is never entered at floor 3 and MOVE_DOWN never at floor 0; now_floor never wraps.
REQ-023 If a latch set and a clear of the same pending bit fall on the same edge, the clear wins.
REQ-024 A call for now_floor that arrives during MOVE is latched and served only when the car next arrives at that floor.

Reset
REQ-025 rst=0 forces, asynchronously: state IDLE, now_floor=0, pointer=00, door_state=0, pending=0, last_dir=up, prescaler=0, timer=0.
REQ-026 Reset asserted mid-move or with the door open aborts the operation with no residual pending calls; operation resumes on the first clk edge after rst=1.

Verification (TICK_DIV=4, MOVE_TICKS=2, DOOR_TICKS=3)
REQ-027 Assert rst=0 while moving at floor 2 -> next sample shows now_floor=0, pointer=00, door_state=0, pending=0 without waiting for a clk edge.
REQ-028 In IDLE at floor 0, pulse call_req=0001 for one clk -> door_state=1 and pending=0000 on the next edge; door_state=0 after 3 ticks (9-12 clks).
REQ-029 In IDLE at floor 0, pulse call_req=1000 -> pointer=01 on the next edge; now_floor steps 1,2,3, one step every 2 ticks; at floor 3 door_state=1, pointer=00, pending=0000.
REQ-030 Moving up at floor 2 with pending=1001 -> the car serves floor 3 first, then pointer=10 and it descends to 0 and opens the door; floor 0 is never served first.
REQ-031 With the door open at floor 1, hold call_req=0010 high for 2 ticks -> door_state stays 1 until 3 ticks after release and pending[1] stays 0.
REQ-032 Pulse call_req=0100 while moving down past floor 3 towards 0 with pending=0001 -> the car opens at 0, then moves up and opens at 2; pointer never reads 11 and now_floor never leaves 0..3.
